arith_result_serializer: RTL and testbench
==========================================

# arith_result_serializer

Downstream stage of the six-output arithmetic datapath (sum, product, modulo-plus, chained sum, difference, combined sum). It captures one frame of six BW-bit results under a valid/ready handshake and emits them one word per cycle on a single BW-bit stream, tagged with an index and a last flag. This narrows the six parallel result buses to one bus for the result sink, at full throughput for back-to-back frames.

## Interface
- BW, default 8, width of every result word and of out_data
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  frame s1..s6 valid this cycle
- in_ready  output  1  serializer can accept a frame this cycle
- s1, s2, s3, s4, s5, s6  input  BW each  results from the arithmetic datapath
- out_valid  output  1  out_data/out_idx/out_last valid
- out_ready  input  1  sink accepts the current word
- out_data  output  BW  current result word
- out_idx  output  3  index of current word (0 = s1 … 5 = s6, 6 = checksum)
- out_last  output  1  high on final word of frame
- frame_cnt  output  16  completed frames, wraps 0xFFFF -> 0x0000

## Operation
- Capture registers hold six words (seven with RESULT_SUM_EN), written only on accept (in_valid && in_ready).
- FSM states: IDLE, SEND.
  - IDLE: in_ready=1, out_valid=0. On accept -> SEND, idx=0.
  - SEND: out_valid=1, out_data = word[idx]. On out_valid && out_ready: if not last, idx+1; if last, frame_cnt+1, and either reload (accept same cycle) with idx=0 staying in SEND, or -> IDLE.
- in_ready = IDLE || (SEND && out_ready && out_last). No other accepts; a frame is never overwritten mid-send.
- in_valid while in_ready=0 is ignored; the upstream holds it. No requirement that in_valid stay high.
- out_last = (idx == LAST), LAST = 5, or 6 with RESULT_SUM_EN.
- Outputs (out_data, out_idx, out_last) stay stable while out_valid && !out_ready.
- Reset (any time, including mid-frame): state=IDLE, idx=0, out_valid=0, out_data=0, out_idx=0, out_last=0, frame_cnt=0, capture regs=0, in_ready=1 after release. The partial frame is dropped and not counted.

## Timing
- Latency: accept at edge N -> out_valid with idx 0 after edge N (visible in cycle N+1).
- Throughput: one word per cycle with out_ready held high. Back-to-back frames have no bubble: the next frame's idx 0 directly follows the previous last word.
- Frame length: 6 cycles minimum (7 with RESULT_SUM_EN).
- in_ready is combinational from state, out_ready and out_last. There is no combinational path from in_valid to out_*.
- frame_cnt increments on the edge at which the last word handshakes.

## Configuration
- RESULT_SUM_EN defined: the checksum (s1+s2+s3+s4+s5+s6) mod 2^BW is computed from the inputs and registered at accept. It is emitted as a seventh word with out_idx=6, and out_last moves to idx 6.
- RESULT_SUM_EN undefined: there is no checksum register or adder. Frames are six words and out_idx never reaches 6.

## Test plan
- Single frame, BW=8, source a=5,b=3,c=2,d=1: s1..s6 = 8,15,3,18,2,20, out_ready=1 -> out_data 8,15,3,18,2,20 on consecutive cycles with idx 0..5, out_last only on 20, frame_cnt=1. With RESULT_SUM_EN, an extra word 0x42 appears at idx 6 with out_last.
- Back-to-back: in_valid held high over two frames -> 12 consecutive valid words with no gap, in_ready pulses high exactly on each last-word cycle, frame_cnt=2.
- Backpressure: drop out_ready for 3 cycles at idx 2 -> out_data=3 and idx=2 are held and stable, then the sequence resumes with 18. in_valid during the stall is not accepted.
- Capture isolation: change s1..s6 to 0xFF after accept, mid-frame -> the remaining words still come from the captured frame.
- Reset mid-frame: assert rst at idx 3 -> out_valid=0 immediately (asynchronous), frame_cnt unchanged at 0, in_ready=1 after release, and the next frame starts at idx 0.
- Counter wrap: preload by running 65535 frames (or force) -> the next completed frame sets frame_cnt=0x0000.

Source files
------------

// File: rtl/arith_result_serializer.sv
// Serializes one frame of six BW-bit arithmetic results into a tagged word stream.
// Optional RESULT_SUM_EN appends a registered mod-2^BW checksum as a seventh word.
module arith_result_serializer #(
  parameter int BW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] s1,
  input  logic [BW-1:0] s2,
  input  logic [BW-1:0] s3,
  input  logic [BW-1:0] s4,
  input  logic [BW-1:0] s5,
  input  logic [BW-1:0] s6,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] out_data,
  output logic [2:0]    out_idx,
  output logic          out_last,
  output logic [15:0]   frame_cnt
);

  // Handshakes: a word/frame transfers on the rising edge where valid && ready;
  // the sender holds valid and payload until then, the receiver may toggle ready freely.

`ifdef RESULT_SUM_EN
  localparam logic [2:0] LAST = 3'd6;
`else
  localparam logic [2:0] LAST = 3'd5;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  idx;
  logic [2:0]  idx_nxt;
  logic        accept;
  logic        frame_done;

  logic [BW-1:0] w1, w2, w3, w4, w5, w6;
`ifdef RESULT_SUM_EN
  logic [BW-1:0] wsum;
  logic [BW-1:0] sum_in;

  assign sum_in = s1 + s2 + s3 + s4 + s5 + s6;
`endif

  assign accept     = in_valid && in_ready;
  assign frame_done = (state == SEND) && out_ready && (idx == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= 3'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // in_ready is only asserted while idle or on the handshake of the final word,
  // so a captured frame can never be overwritten before it is fully sent.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = SEND;
          idx_nxt   = 3'd0;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (idx == LAST) begin
            in_ready  = 1'b1;
            idx_nxt   = 3'd0;
            state_nxt = in_valid ? SEND : IDLE;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w1 <= '0;
      w2 <= '0;
      w3 <= '0;
      w4 <= '0;
      w5 <= '0;
      w6 <= '0;
    end else if (accept) begin
      w1 <= s1;
      w2 <= s2;
      w3 <= s3;
      w4 <= s4;
      w5 <= s5;
      w6 <= s6;
    end
  end

`ifdef RESULT_SUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wsum <= '0;
    end else if (accept) begin
      wsum <= sum_in;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= 16'd0;
    end else if (frame_done) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Output word is a pure function of the capture registers and idx, so it
  // holds steady under backpressure and never sees in_valid combinationally.
  always_comb begin
    out_data = '0;
    if (state == SEND) begin
      case (idx)
        3'd0:    out_data = w1;
        3'd1:    out_data = w2;
        3'd2:    out_data = w3;
        3'd3:    out_data = w4;
        3'd4:    out_data = w5;
        3'd5:    out_data = w6;
`ifdef RESULT_SUM_EN
        3'd6:    out_data = wsum;
`endif
        default: out_data = '0;
      endcase
    end
  end

  assign out_idx  = idx;
  assign out_last = (state == SEND) && (idx == LAST);

endmodule

// File: tb/tb_arith_result_serializer.sv
// Self-checking bench for arith_result_serializer: queue-based frame model,
// directed scenarios plus randomized traffic. Honors RESULT_SUM_EN like the RTL.
module tb_arith_result_serializer;

  localparam int BW = 8;
  localparam int EW = BW + 4;
`ifdef RESULT_SUM_EN
  localparam int NW = 7;
`else
  localparam int NW = 6;
`endif

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] s1, s2, s3, s4, s5, s6;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic [2:0]    out_idx;
  logic          out_last;
  logic [15:0]   frame_cnt;

  // Expected words of the frame in flight: {last, idx[2:0], data}.
  logic [EW-1:0] exp_q[$];
  logic [15:0]   exp_frames;
  int            checks;
  int            errors;

  arith_result_serializer #(.BW(BW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s1        (s1),
    .s2        (s2),
    .s3        (s3),
    .s4        (s4),
    .s5        (s5),
    .s6        (s6),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push_frame();
    logic [BW-1:0] w[7];
    w[0] = s1; w[1] = s2; w[2] = s3; w[3] = s4; w[4] = s5; w[5] = s6;
    w[6] = s1 + s2 + s3 + s4 + s5 + s6;
    for (int i = 0; i < NW; i++)
      exp_q.push_back({(i == NW - 1), 3'(i), w[i]});
  endtask

  // Checks outputs mid-cycle, then applies what the coming edge should do.
  task automatic step();
    logic exp_ready;
    logic [EW-1:0] e;
    @(negedge clk);
    exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
    check_eq("in_ready", in_ready, exp_ready);
    check_eq("out_valid", out_valid, exp_q.size() != 0);
    check_eq("frame_cnt", frame_cnt, exp_frames);
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      check_eq("out_data", out_data, e[BW-1:0]);
      check_eq("out_idx", out_idx, e[BW+2:BW]);
      check_eq("out_last", out_last, e[BW+3]);
      if (out_ready) begin
        void'(exp_q.pop_front());
        if (e[BW+3]) exp_frames = exp_frames + 16'd1;
      end
    end
    if (in_valid && exp_ready) push_frame();
    @(posedge clk);
    #1;
  endtask

  task automatic set_frame(input logic [BW-1:0] a, b, c, d, e, f);
    s1 = a; s2 = b; s3 = c; s4 = d; s5 = e; s6 = f;
  endtask

  task automatic step_until_idx(input logic [2:0] target);
    int n;
    n = 0;
    while (!(exp_q.size() != 0 && exp_q[0][BW+2:BW] == target) && n < 20) begin
      step();
      n++;
    end
    check_eq("idx_reached", n < 20, 1);
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      step();
      n++;
    end
    check_eq("drain_bound", n < 40, 1);
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_frames = 16'd0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    set_frame(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_idx", out_idx, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_frame_cnt", frame_cnt, 0);
    rst = 1'b0;
    step();

    // Reset mid-frame at idx 3: outputs drop asynchronously, frame not counted.
    set_frame(8'd8, 8'd15, 8'd3, 8'd18, 8'd2, 8'd20);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step_until_idx(3'd3);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_out_idx", out_idx, 0);
    check_eq("midrst_out_last", out_last, 0);
    check_eq("midrst_out_data", out_data, 0);
    check_eq("midrst_frame_cnt", frame_cnt, 0);
    exp_q.delete();
    exp_frames = 16'd0;
    @(posedge clk);
    #1 rst = 1'b0;
    step();

    // Single reference frame (a=5,b=3,c=2,d=1), checksum 0x42 when enabled.
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    drain();
    check_eq("single_frame_cnt", frame_cnt, 1);

    // Back-to-back: in_valid held over two frames.
    in_valid = 1'b1;
    step();
    set_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66);
    repeat (NW) step();
    in_valid = 1'b0;
    drain();
    check_eq("b2b_frame_cnt", frame_cnt, 3);

    // Backpressure at idx 2 for 3 cycles with in_valid pending.
    set_frame(8'd8, 8'd15, 8'd3, 8'd18, 8'd2, 8'd20);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step_until_idx(3'd2);
    set_frame(8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5);
    in_valid = 1'b1;
    out_ready = 1'b0;
    repeat (3) step();
    check_eq("stall_hold_data", out_data, 3);
    in_valid = 1'b0;
    drain();

    // Capture isolation: inputs go to 0xFF mid-frame.
    set_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    set_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      set_frame($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
      step();
    end
    drain();

    // Counter wrap: preload near the top, then complete two frames.
    force dut.frame_cnt = 16'hFFFE;
    #1 release dut.frame_cnt;
    exp_frames = 16'hFFFE;
    set_frame($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    in_valid = 1'b1;
    step();
    repeat (NW) step();
    in_valid = 1'b0;
    drain();
    check_eq("wrap_frame_cnt", frame_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
